// File: rtl/bram_arb_pkg.sv
// Shared types and defaults for the BRAM port arbiter.
// Requester indices name the fixed clients wired to ports 0..3.
package bram_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int AW_DEF   = 10;
    localparam int DW_DEF   = 32;

    localparam int REQ_WB   = 0;
    localparam int REQ_FIR  = 1;
    localparam int REQ_MM   = 2;
    localparam int REQ_UART = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARB    = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bram_arbiter_rr_pick.sv
// Round-robin picker: scans requesters starting just after last_grant and
// returns a one-hot grant for the first active one (all-zero when none).
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_vec,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] grant
);

    function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Scanning from the farthest offset down lets the nearest requester win last.
    always_comb begin
        grant = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_vec[rot_idx(last_grant, k)]) begin
                grant = '0;
                grant[rot_idx(last_grant, k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Single-port BRAM arbiter: round-robin among NREQ requesters with optional
// locked bursts and a fixed-latency read-response tag pipeline.
//
// state     | meaning
// ST_IDLE   | no traffic last cycle; a new request is granted immediately
// ST_ARB    | round-robin arbitration after the last granted requester
// ST_LOCKED | owner (last_grant) holds the port for up to MAX_BURST beats
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 8,
    localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int SW       = DW / 8
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    input  logic [NREQ*SW-1:0]   req_wstrb,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 ram_en,
    output logic [SW-1:0]        ram_we,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_wdata,
    input  logic [DW-1:0]        ram_rdata,
    output logic [IW-1:0]        busy_id
);

    localparam int CW       = $clog2(MAX_BURST + 1);
    localparam bit CAN_LOCK = (MAX_BURST > 1);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [IW-1:0]   busy_id_q, busy_id_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [NREQ-1:0] tag_q [RD_LAT];
    logic [NREQ-1:0] tag_d [RD_LAT];

    logic [NREQ-1:0] owner_oh, pick_req, pick_gnt, grant;
    logic [IW-1:0]   gnt_idx;
    logic            locked_hold, gnt_lock, gnt_we;

    // While the owner keeps req_valid it is the only candidate; once it drops,
    // everyone competes in the same cycle.
    always_comb begin
        owner_oh = '0;
        owner_oh[last_grant_q] = 1'b1;
        locked_hold = (state_q == ST_LOCKED) && (|(req_valid & owner_oh));
        pick_req    = locked_hold ? owner_oh : req_valid;
    end

    rr_pick #(
        .NREQ(NREQ),
        .IW  (IW)
    ) u_rr_pick (
        .req_vec   (pick_req),
        .last_grant(last_grant_q),
        .grant     (pick_gnt)
    );

    // Gating with resetb keeps the combinational command path quiet during reset.
    always_comb begin
        grant   = pick_gnt & {NREQ{resetb}};
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) gnt_idx = IW'(i);
        end
        gnt_lock = |(grant & req_lock);
        gnt_we   = |(grant & req_we);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IW'(NREQ - 1);
            busy_id_q    <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            busy_id_q    <= busy_id_d;
            cnt_q        <= cnt_d;
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= tag_d[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        busy_id_d    = busy_id_q;
        cnt_d        = cnt_q;
        cnt_inc      = cnt_q + CW'(1);
        if (|grant) begin
            last_grant_d = gnt_idx;
            busy_id_d    = gnt_idx;
            if (locked_hold) begin
                if (gnt_lock && (cnt_inc < CW'(MAX_BURST))) begin
                    state_d = ST_LOCKED;
                    cnt_d   = cnt_inc;
                end else begin
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end
            end else if (gnt_lock && CAN_LOCK) begin
                state_d = ST_LOCKED;
                cnt_d   = CW'(1);
            end else begin
                state_d = ST_ARB;
                cnt_d   = '0;
            end
        end else begin
            cnt_d   = '0;
            state_d = (state_q == ST_LOCKED) ? ST_ARB : ST_IDLE;
        end

        tag_d[0] = grant & ~req_we;
        for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    end

    always_comb begin
        req_ready = grant;
        ram_en    = |grant;
        ram_we    = gnt_we ? req_wstrb[int'(gnt_idx)*SW +: SW] : '0;
        ram_addr  = req_addr[int'(gnt_idx)*AW +: AW];
        ram_wdata = req_wdata[int'(gnt_idx)*DW +: DW];
        rsp_valid = tag_q[RD_LAT-1];
        rsp_rdata = (|tag_q[RD_LAT-1]) ? ram_rdata : '0;
        busy_id   = busy_id_q;
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a 1-cycle BRAM model.
module tb_bram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;

    logic                clock = 1'b0;
    logic                resetb = 1'b0;
    logic [NREQ-1:0]     req_valid, req_lock, req_we;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ*SW-1:0]  req_wstrb;
    logic [NREQ-1:0]     req_ready, rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic                ram_en;
    logic [SW-1:0]       ram_we;
    logic [AW-1:0]       ram_addr;
    logic [DW-1:0]       ram_wdata;
    logic [DW-1:0]       ram_rdata = '0;
    logic [1:0]          busy_id;

    logic [DW-1:0] mem [1 << AW];
    bit            mem_loaded = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    int exp_burst [13] = '{2, 2, 2, 2, 2, 2, 2, 2, 0, 2, 2, 2, 2};

    bram_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1), .MAX_BURST(8)
    ) dut (
        .clock    (clock),
        .resetb   (resetb),
        .req_valid(req_valid),
        .req_lock (req_lock),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .busy_id  (busy_id)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!mem_loaded) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem[10'h010] <= 32'h0000_003E;
            mem[10'h3FF] <= 32'h1234_5678;
            mem_loaded   <= 1'b1;
        end else if (ram_en) begin
            ram_rdata <= mem[ram_addr];
            for (int b = 0; b < SW; b++)
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_lock  = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
    endtask

    task automatic set_req(input int i, input bit we, input bit lock, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_lock[i]           = lock;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_wstrb[i*SW +: SW] = s;
    endtask

    task automatic apply_reset();
        clear_reqs();
        resetb = 1'b0;
        @(negedge clock);
        resetb = 1'b1;
    endtask

    initial begin
        int n2;
        bit done0;
        clear_reqs();

        // Reset: a pending request must not leak through while resetb is low.
        set_req(0, 1'b1, 1'b0, 10'h001, 32'hFFFF_FFFF, 4'hF);
        @(negedge clock);
        #1;
        check_val("rst_ready", req_ready, 0);
        check_val("rst_ram_en", ram_en, 0);
        check_val("rst_ram_we", ram_we, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_busy_id", busy_id, 0);
        check_val("rst_rdata", rsp_rdata, 0);
        clear_reqs();
        resetb = 1'b1;

        // Single read from requester 1.
        @(negedge clock);
        set_req(1, 1'b0, 1'b0, 10'h010, '0, '0);
        #1;
        check_val("rd1_ready", req_ready, 4'b0010);
        check_val("rd1_ram_en", ram_en, 1);
        check_val("rd1_ram_addr", ram_addr, 10'h010);
        check_val("rd1_ram_we", ram_we, 0);
        @(negedge clock);
        clear_reqs();
        #1;
        check_val("rd1_rsp_valid", rsp_valid, 4'b0010);
        check_val("rd1_rdata", rsp_rdata, 32'h0000_003E);
        check_val("idle_ram_en", ram_en, 0);
        check_val("idle_ram_we", ram_we, 0);
        @(negedge clock);
        #1;
        check_val("rd1_rsp_done", rsp_valid, 0);

        // Fairness with back-to-back reads; responses trail grants by one cycle.
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            clear_reqs();
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 10'(i*4 + 1), '0, '0);
            #1;
            check_val($sformatf("rr_ready_%0d", k), req_ready, 64'(1 << (k % 4)));
            if (k > 0) begin
                check_val($sformatf("rr_rsp_%0d", k), rsp_valid, 64'(1 << ((k-1) % 4)));
                check_val($sformatf("rr_rdata_%0d", k), rsp_rdata,
                          32'hC0DE_0000 | 32'(((k-1) % 4) * 4 + 1));
            end
        end
        @(negedge clock);
        clear_reqs();
        #1;
        check_val("rr_rsp_last", rsp_valid, 4'b1000);
        check_val("rr_rdata_last", rsp_rdata, 32'hC0DE_000D);

        // Burst cap: one beat from requester 1 so requester 2 is next in turn.
        @(negedge clock);
        set_req(1, 1'b0, 1'b0, 10'h005, '0, '0);
        #1;
        check_val("pre_ready", req_ready, 4'b0010);
        n2 = 0;
        done0 = 1'b0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clock);
            clear_reqs();
            if (n2 < 12) set_req(2, 1'b0, 1'b1, 10'(32 + k), '0, '0);
            if (!done0)  set_req(0, 1'b0, 1'b0, 10'h002, '0, '0);
            #1;
            check_val($sformatf("burst_%0d", k), req_ready, 64'(1 << exp_burst[k]));
            if (exp_burst[k] == 2) n2++;
            else done0 = 1'b1;
        end
        @(negedge clock);
        clear_reqs();
        #1;
        check_val("burst_end_en", ram_en, 0);

        // Lock release: owner 3 drops valid for a cycle, requester 1 gets in.
        @(negedge clock);
        set_req(3, 1'b0, 1'b1, 10'h030, '0, '0);
        #1;
        check_val("lk_first", req_ready, 4'b1000);
        @(negedge clock);
        clear_reqs();
        set_req(3, 1'b0, 1'b1, 10'h031, '0, '0);
        set_req(1, 1'b0, 1'b0, 10'h011, '0, '0);
        #1;
        check_val("lk_hold", req_ready, 4'b1000);
        @(negedge clock);
        clear_reqs();
        set_req(1, 1'b0, 1'b0, 10'h011, '0, '0);
        #1;
        check_val("lk_release", req_ready, 4'b0010);
        @(negedge clock);
        clear_reqs();
        #1;
        check_val("lk_busy_id", busy_id, 1);

        // Partial write to the last address, then read it back.
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 10'h3FF, 32'hFFFF_AB51, 4'b0011);
        #1;
        check_val("wr_ready", req_ready, 4'b0001);
        check_val("wr_ram_we", ram_we, 4'b0011);
        check_val("wr_ram_addr", ram_addr, 10'h3FF);
        check_val("wr_ram_wdata", ram_wdata, 32'hFFFF_AB51);
        @(negedge clock);
        clear_reqs();
        set_req(0, 1'b0, 1'b0, 10'h3FF, '0, '0);
        #1;
        check_val("wr_no_rsp", rsp_valid, 0);
        check_val("rb_ready", req_ready, 4'b0001);
        @(negedge clock);
        clear_reqs();
        #1;
        check_val("rb_rsp_valid", rsp_valid, 4'b0001);
        check_val("rb_rdata", rsp_rdata, 32'h1234_AB51);

        // Reset right after a read is accepted: the response must vanish.
        @(negedge clock);
        set_req(2, 1'b0, 1'b0, 10'h010, '0, '0);
        #1;
        check_val("rr_mid_ready", req_ready, 4'b0100);
        @(posedge clock);
        #1;
        resetb = 1'b0;
        clear_reqs();
        #1;
        check_val("mid_rsp_valid", rsp_valid, 0);
        check_val("mid_rdata", rsp_rdata, 0);
        @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        set_req(3, 1'b0, 1'b0, 10'h010, '0, '0);
        set_req(0, 1'b0, 1'b0, 10'h010, '0, '0);
        #1;
        check_val("post_rst_rsp", rsp_valid, 0);
        check_val("post_rst_grant", req_ready, 4'b0001);
        @(negedge clock);
        clear_reqs();
        #1;
        check_val("post_rst_rd", rsp_valid, 4'b0001);
        check_val("post_rst_rdata", rsp_rdata, 32'h0000_003E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (0 = mgmt-core Wishbone bridge, 1 = FIR, 2 = matmul, 3 = UART buffer).
REQ-002 SHALL have parameter AW, default 10, BRAM word-address width.
REQ-003 SHALL have parameter DW, default 32, data width; byte strobes are DW/8 bits.
REQ-004 SHALL have parameter RD_LAT, default 1, fixed BRAM read latency in cycles (1..3).
REQ-005 SHALL have parameter MAX_BURST, default 8, maximum consecutive locked grants to one requester.
REQ-006 SHALL have port: clock  input  1  single clock for all logic.
REQ-007 SHALL have port: resetb  input  1  asynchronous active-low reset.
REQ-008 SHALL have port: req_valid  input  NREQ  per-requester access request.
REQ-009 SHALL have port: req_lock  input  NREQ  requester asks to keep its grant for the next beat.
REQ-010 SHALL have port: req_we  input  NREQ  1 = write, 0 = read.
REQ-011 SHALL have port: req_addr  input  NREQ*AW  flattened word addresses, requester i at [i*AW +: AW].
REQ-012 SHALL have port: req_wdata  input  NREQ*DW  flattened write data.
REQ-013 SHALL have port: req_wstrb  input  NREQ*DW/8  flattened byte strobes.
REQ-014 SHALL have port: req_ready  output  NREQ  one-hot; beat accepted this cycle.
REQ-015 SHALL have port: rsp_valid  output  NREQ  one-hot; read data valid for requester i.
REQ-016 SHALL have port: rsp_rdata  output  DW  read data, shared by all requesters.
REQ-017 SHALL have ports: ram_en output 1, ram_we output DW/8, ram_addr output AW, ram_wdata output DW, ram_rdata input DW, which form the BRAM port.
REQ-018 SHALL have port: busy_id  output  log2(NREQ)  index of the current or last granted requester.

Function
REQ-019 SHALL accept at most one beat per cycle; a beat transfers when req_valid[i] and req_ready[i] are both high.
REQ-020 SHALL drive req_ready combinationally from the current req_valid and arbiter state; the BRAM command is presented in the same cycle (ram_en=1, ram_we = wstrb if req_we else 0).
REQ-021 SHALL implement FSM states IDLE, ARB and LOCKED.
REQ-022 IDLE: go to ARB when any req_valid is high; the first grant is issued in that same cycle.
REQ-023 ARB: grant round-robin starting at (last_grant+1) mod NREQ; if no request is pending, go to IDLE.
REQ-024 ARB -> LOCKED: when the granted beat has req_lock=1 and MAX_BURST>1; beat counter set to 1.
REQ-025 LOCKED: only the owner is eligible; each accepted beat increments the counter.
REQ-026 LOCKED -> ARB: when the owner beat has req_lock=0, when the counter reaches MAX_BURST, or when the owner drops req_valid; round-robin then resumes after the owner.
REQ-027 In LOCKED, if the owner's req_valid is low for one cycle, SHALL release the lock and arbitrate the others in that same cycle.
REQ-028 SHALL return read data exactly RD_LAT cycles after acceptance via a RD_LAT-deep tag pipeline; rsp_valid is one-hot with the tag; writes produce no response.
REQ-029 With back-to-back reads from different requesters, SHALL deliver responses in acceptance order, one per cycle, with no bubbles.
REQ-030 With no grant, SHALL hold ram_en=0 and ram_we=0; ram_addr and ram_wdata are don't-care.
REQ-031 last_grant SHALL wrap from NREQ-1 to 0.
REQ-032 The counter SHALL be ceil(log2(MAX_BURST+1)) bits wide and never exceed MAX_BURST.

Reset
REQ-033 On resetb low, SHALL asynchronously force: FSM=IDLE, last_grant=NREQ-1 (so requester 0 wins first), counter=0, tag pipeline cleared, req_ready=0, rsp_valid=0, ram_en=0, ram_we=0, busy_id=0, rsp_rdata=0.
REQ-034 Reads in flight when reset asserts SHALL be discarded; no rsp_valid after deassertion.
REQ-035 Reset deassertion SHALL be synchronised externally; the first grant can occur on the first rising clock edge after release.

Structure
REQ-036 Package bram_arb_pkg SHALL hold the FSM state enum, the default NREQ/AW/DW constants and the requester index constants (REQ_WB, REQ_FIR, REQ_MM, REQ_UART).
REQ-037 The round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, last grant; output: one-hot grant), with the FSM, counter and tag pipeline in bram_arbiter.

Verification
REQ-038 Single read: requester 1 reads addr 0x010 holding 0x0000003E -> req_ready[1] in the same cycle; rsp_valid=0b0010 and rsp_rdata=0x0000003E RD_LAT cycles later.
REQ-039 Fairness: all four requesters hold req_valid with lock=0 for 8 cycles -> grant order 0,1,2,3,0,1,2,3.
REQ-040 Burst cap: requester 2 holds lock=1 for 12 beats while requester 0 also requests -> 8 beats to 2, then 0 is granted, then 2 resumes.
REQ-041 Lock release: requester 3 is locked and drops req_valid for one cycle while requester 1 requests -> requester 1 is granted in that cycle.
REQ-042 Write/readback: requester 0 writes 0xAB51 with wstrb=0b0011 to addr 0x3FF (last address), then reads it -> upper bytes unchanged, lower half 0xAB51.
REQ-043 Reset mid-read: assert resetb low one cycle after a read is accepted -> no rsp_valid; after release, requester 0 wins the first grant.
